// File: rtl/qmem_pkg.sv
// qmem_pkg: shared definitions for the qmem_slave memory target.
// Holds the FSM state encoding, the wait-state counter width and a
// ceiling-log2 helper used to size the byte-offset field of the address.
package qmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Wait-state counter width; covers LAT up to 15.
  localparam int CNT_W = 4;

  function automatic int CLOG2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/qmem_ram.sv
// qmem_ram: single-port, byte-enabled RAM of 2^MAW words x QDW bits.
// Read data is registered and only updates when re_i is high, so the
// output holds the last word read. Contents are never reset.
module qmem_ram #(
  parameter int QDW = 32,
  parameter int QSW = QDW / 8,
  parameter int MAW = 10
) (
  input  logic           clk_i,
  input  logic           we_i,
  input  logic           re_i,
  input  logic [QSW-1:0] be_i,
  input  logic [MAW-1:0] addr_i,
  input  logic [QDW-1:0] wdata_i,
  output logic [QDW-1:0] rdata_o
);

  localparam int BW = QDW / QSW;

  logic [QDW-1:0] mem_q [2**MAW];
  logic [QDW-1:0] rdata_q;

  // Synchronous read into the output register, byte-lane writes.
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem_q[addr_i];
    if (we_i) begin
      for (int i = 0; i < QSW; i++) begin
        if (be_i[i]) mem_q[addr_i][i*BW +: BW] <= wdata_i[i*BW +: BW];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/qmem_slave.sv
// qmem_slave: memory target with a cs/ack handshake and LAT wait states.
// A request is accepted in IDLE or RESP, waits LAT cycles in WAIT, and is
// answered for exactly one cycle in RESP. Back-to-back requests re-accept
// straight out of RESP. Dropping cs while waiting aborts the transfer.
// Optional feature: define QMEM_SLAVE_ERR_EN to answer requests whose
// address has bits set above the memory range with err instead of ack;
// without it err is tied low and upper address bits alias.
module qmem_slave #(
  parameter int QAW = 32,
  parameter int QDW = 32,
  parameter int QSW = QDW / 8,
  parameter int MAW = 10,
  parameter int LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cs,
  input  logic           we,
  input  logic [QSW-1:0] sel,
  input  logic [QAW-1:0] adr,
  input  logic [QDW-1:0] dat_i,
  output logic [QDW-1:0] dat_o,
  output logic           ack,
  output logic           err
);

  import qmem_pkg::*;

  localparam int                WB      = CLOG2(QSW);
  localparam bit                LAT0    = (LAT == 0);
  localparam logic [CNT_W-1:0]  LAT_CNT = CNT_W'(LAT);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             latch;
  logic             enter_resp;

  // Latched request
  logic             we_q;
  logic [QSW-1:0]   sel_q;
  logic [MAW-1:0]   widx_q;
  logic [QDW-1:0]   wdat_q;
  logic             errf_q;

  // Request as seen by the RAM on the edge entering RESP
  logic             r_we;
  logic [QSW-1:0]   r_sel;
  logic [MAW-1:0]   r_widx;
  logic [QDW-1:0]   r_dat;
  logic             r_err;

  logic [MAW-1:0]   adr_widx;
  logic             adr_err;
  logic             unused_adr;

  logic             ram_we, ram_re;
  logic [QDW-1:0]   ram_rdata;
  logic             rd_vld_q;

  assign adr_widx   = adr[WB +: MAW];
  assign unused_adr = ^adr;

`ifdef QMEM_SLAVE_ERR_EN
  assign adr_err = |(adr >> (WB + MAW));
`else
  assign adr_err = 1'b0;
`endif

  // Next-state logic: accept, count wait states, abort on cs drop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    unique case (state_q)
      IDLE, RESP: begin
        if (cs) begin
          latch = 1'b1;
          if (LAT0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_CNT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (!cs) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_ONE) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // With no wait states the request is serviced on the accepting edge, so
  // the RAM sees the live inputs; otherwise it sees the latched copy.
  assign enter_resp = (latch && LAT0) || (state_q == WAIT && state_d == RESP);
  assign r_we   = LAT0 ? we       : we_q;
  assign r_sel  = LAT0 ? sel      : sel_q;
  assign r_widx = LAT0 ? adr_widx : widx_q;
  assign r_dat  = LAT0 ? dat_i    : wdat_q;
  assign r_err  = LAT0 ? adr_err  : errf_q;

  // RAM access is suppressed while reset is asserted so a pending write
  // can never commit on a reset edge.
  assign ram_we = rst_n && enter_resp &&  r_we && !r_err;
  assign ram_re = rst_n && enter_resp && !r_we && !r_err;

  // State, counter and request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      widx_q  <= '0;
      wdat_q  <= '0;
      errf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        we_q   <= we;
        sel_q  <= sel;
        widx_q <= adr_widx;
        wdat_q <= dat_i;
        errf_q <= adr_err;
      end
    end
  end

  // Marks that the RAM read register holds a word read since reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_vld_q <= 1'b0;
    else if (ram_re) rd_vld_q <= 1'b1;
  end

  qmem_ram #(
    .QDW (QDW),
    .QSW (QSW),
    .MAW (MAW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .be_i    (r_sel),
    .addr_i  (r_widx),
    .wdata_i (r_dat),
    .rdata_o (ram_rdata)
  );

  assign dat_o = rd_vld_q ? ram_rdata : '0;
  assign ack   = (state_q == RESP) && !errf_q;
`ifdef QMEM_SLAVE_ERR_EN
  assign err   = (state_q == RESP) && errf_q;
`else
  assign err   = 1'b0;
`endif

endmodule
